// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: round-robin share of the dcache request port between EX1 and CACOP-D,
// holding each request until handshake and silently completing flushed memory requests.
module dcache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              p_valid,
    input  logic              p_op,
    input  logic [3:0]        p_wstrb,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              p_atom,
    output logic              p_ready,
    output logic              p_resp_valid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              c_valid,
    input  logic [1:0]        c_type,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              c_ready,
    output logic              c_done,
    output logic              d_rvalid,
    output logic              d_wvalid,
    output logic              d_op,
    output logic [3:0]        d_wstrb,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              d_atom,
    input  logic              d_rready,
    input  logic              d_wready,
    input  logic [DATA_W-1:0] d_rdata,
    output logic              d_cacop_en,
    output logic [1:0]        d_cacop_type,
    output logic [ADDR_W-1:0] d_cacop_addr,
    input  logic              d_cacop_ready,
    input  logic              d_cacop_done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MEM_WAIT = 3'd1;
    localparam logic [2:0] MEM_DROP = 3'd2;
    localparam logic [2:0] CAC_REQ  = 3'd3;
    localparam logic [2:0] CAC_WAIT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              d_rvalid_q, d_rvalid_d, d_wvalid_q, d_wvalid_d;
    logic              d_op_q, d_op_d, d_atom_q, d_atom_d;
    logic [3:0]        d_wstrb_q, d_wstrb_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d, d_cacop_addr_q, d_cacop_addr_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d, p_rdata_q, p_rdata_d;
    logic              d_cacop_en_q, d_cacop_en_d;
    logic [1:0]        d_cacop_type_q, d_cacop_type_d;
    logic              p_resp_valid_q, p_resp_valid_d, c_done_q, c_done_d;
    logic              p_elig, grant_p, grant_c, mem_done;

    // last_grant_q = 1 means cacop was granted last, so the pipeline wins the next tie
    assign p_elig   = p_valid & ~flush;
    assign grant_p  = (state_q == IDLE) & p_elig & (~c_valid | last_grant_q);
    assign grant_c  = (state_q == IDLE) & c_valid & (~p_elig | ~last_grant_q);
    assign mem_done = d_rvalid_q ? d_rready : d_wready;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        d_rvalid_d     = d_rvalid_q;
        d_wvalid_d     = d_wvalid_q;
        d_op_d         = d_op_q;
        d_wstrb_d      = d_wstrb_q;
        d_addr_d       = d_addr_q;
        d_wdata_d      = d_wdata_q;
        d_atom_d       = d_atom_q;
        d_cacop_en_d   = d_cacop_en_q;
        d_cacop_type_d = d_cacop_type_q;
        d_cacop_addr_d = d_cacop_addr_q;
        p_resp_valid_d = 1'b0;
        p_rdata_d      = '0;
        c_done_d       = 1'b0;
        if (grant_p) begin
            state_d      = MEM_WAIT;
            last_grant_d = 1'b0;
            d_rvalid_d   = ~p_op;
            d_wvalid_d   = p_op;
            d_op_d       = p_op;
            d_wstrb_d    = p_wstrb;
            d_addr_d     = p_addr;
            d_wdata_d    = p_wdata;
            d_atom_d     = p_atom;
        end else if (grant_c) begin
            state_d        = CAC_REQ;
            last_grant_d   = 1'b1;
            d_cacop_en_d   = 1'b1;
            d_cacop_type_d = c_type;
            d_cacop_addr_d = c_addr;
        end
        if ((state_q == MEM_WAIT || state_q == MEM_DROP) && mem_done) begin
            state_d        = IDLE;
            d_rvalid_d     = 1'b0;
            d_wvalid_d     = 1'b0;
            p_resp_valid_d = (state_q == MEM_WAIT) & ~flush;
            p_rdata_d      = (p_resp_valid_d & ~d_op_q) ? d_rdata : '0;
        end else if (state_q == MEM_WAIT && flush) begin
            state_d = MEM_DROP;
        end
        if (state_q == CAC_REQ && d_cacop_ready) begin
            d_cacop_en_d = 1'b0;
            state_d      = d_cacop_done ? IDLE : CAC_WAIT;
            c_done_d     = d_cacop_done;
        end
        if (state_q == CAC_WAIT && d_cacop_done) begin
            state_d  = IDLE;
            c_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            d_rvalid_q     <= 1'b0;
            d_wvalid_q     <= 1'b0;
            d_op_q         <= 1'b0;
            d_wstrb_q      <= '0;
            d_addr_q       <= '0;
            d_wdata_q      <= '0;
            d_atom_q       <= 1'b0;
            d_cacop_en_q   <= 1'b0;
            d_cacop_type_q <= '0;
            d_cacop_addr_q <= '0;
            p_resp_valid_q <= 1'b0;
            p_rdata_q      <= '0;
            c_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            d_rvalid_q     <= d_rvalid_d;
            d_wvalid_q     <= d_wvalid_d;
            d_op_q         <= d_op_d;
            d_wstrb_q      <= d_wstrb_d;
            d_addr_q       <= d_addr_d;
            d_wdata_q      <= d_wdata_d;
            d_atom_q       <= d_atom_d;
            d_cacop_en_q   <= d_cacop_en_d;
            d_cacop_type_q <= d_cacop_type_d;
            d_cacop_addr_q <= d_cacop_addr_d;
            p_resp_valid_q <= p_resp_valid_d;
            p_rdata_q      <= p_rdata_d;
            c_done_q       <= c_done_d;
        end
    end

    // accept strobes are combinational, so gate them to keep every output low during reset
    assign p_ready      = grant_p & ~rst;
    assign c_ready      = grant_c & ~rst;
    assign p_resp_valid = p_resp_valid_q;
    assign p_rdata      = p_rdata_q;
    assign c_done       = c_done_q;
    assign d_rvalid     = d_rvalid_q;
    assign d_wvalid     = d_wvalid_q;
    assign d_op         = d_op_q;
    assign d_wstrb      = d_wstrb_q;
    assign d_addr       = d_addr_q;
    assign d_wdata      = d_wdata_q;
    assign d_atom       = d_atom_q;
    assign d_cacop_en   = d_cacop_en_q;
    assign d_cacop_type = d_cacop_type_q;
    assign d_cacop_addr = d_cacop_addr_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed vectors for dcache_port_arbiter with hand-computed expectations.
module tb_dcache_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, p_valid, p_op, p_atom;
    logic [3:0]  p_wstrb;
    logic [31:0] p_addr, p_wdata, c_addr, d_rdata;
    logic        p_ready, p_resp_valid, c_valid, c_ready, c_done;
    logic [31:0] p_rdata, d_addr, d_wdata, d_cacop_addr;
    logic [1:0]  c_type, d_cacop_type;
    logic        d_rvalid, d_wvalid, d_op, d_atom, d_rready, d_wready;
    logic [3:0]  d_wstrb;
    logic        d_cacop_en, d_cacop_ready, d_cacop_done;
    int          n_chk = 0;
    int          n_pass = 0;

    dcache_port_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .p_valid(p_valid), .p_op(p_op), .p_wstrb(p_wstrb), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_atom(p_atom), .p_ready(p_ready),
        .p_resp_valid(p_resp_valid), .p_rdata(p_rdata),
        .c_valid(c_valid), .c_type(c_type), .c_addr(c_addr),
        .c_ready(c_ready), .c_done(c_done),
        .d_rvalid(d_rvalid), .d_wvalid(d_wvalid), .d_op(d_op), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_atom(d_atom),
        .d_rready(d_rready), .d_wready(d_wready), .d_rdata(d_rdata),
        .d_cacop_en(d_cacop_en), .d_cacop_type(d_cacop_type), .d_cacop_addr(d_cacop_addr),
        .d_cacop_ready(d_cacop_ready), .d_cacop_done(d_cacop_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // structural invariants sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        chk("onehot", 64'(($countones({d_rvalid, d_wvalid, d_cacop_en}) <= 1)), 64'd1);
        chk("resp_cdone_excl", 64'(p_resp_valid & c_done), 64'd0);
    end

    initial begin
        rst = 1'b1; flush = 0; p_valid = 0; p_op = 0; p_atom = 0; p_wstrb = 0;
        p_addr = 0; p_wdata = 0; c_valid = 0; c_type = 0; c_addr = 0;
        d_rready = 0; d_wready = 0; d_rdata = 0; d_cacop_ready = 0; d_cacop_done = 0;
        #2;
        chk("rst_outs", {p_ready, p_resp_valid, c_ready, c_done, d_rvalid, d_wvalid, d_cacop_en, d_addr}, 0);
        tick();
        rst = 1'b0;
        // load, dcache answers 3 cycles after d_rvalid rises
        p_valid = 1; p_op = 0; p_addr = 32'h1000_0040; #1;
        chk("ld_p_ready", p_ready, 1); chk("ld_rvalid_c0", d_rvalid, 0);
        tick(); p_valid = 0; #1;
        chk("ld_rvalid_c1", d_rvalid, 1); chk("ld_addr", d_addr, 32'h1000_0040); chk("ld_p_ready_c1", p_ready, 0);
        tick(); chk("ld_rvalid_c2", d_rvalid, 1);
        tick(); chk("ld_rvalid_c3", d_rvalid, 1);
        tick(); d_rready = 1; d_rdata = 32'hDEAD_BEEF; #1;
        chk("ld_rvalid_c4", d_rvalid, 1); chk("ld_resp_c4", p_resp_valid, 0);
        tick(); d_rready = 0; d_rdata = 0; #1;
        chk("ld_rvalid_c5", d_rvalid, 0); chk("ld_resp_c5", p_resp_valid, 1); chk("ld_rdata", p_rdata, 32'hDEAD_BEEF);
        tick(); chk("ld_resp_c6", p_resp_valid, 0);
        // store with immediate d_wready
        p_valid = 1; p_op = 1; p_wstrb = 4'b0011; p_wdata = 32'h1234; p_addr = 32'h20; #1;
        chk("st_p_ready", p_ready, 1);
        tick(); p_valid = 0; d_wready = 1; #1;
        chk("st_wvalid", d_wvalid, 1); chk("st_rvalid", d_rvalid, 0); chk("st_wstrb", d_wstrb, 4'b0011); chk("st_wdata", d_wdata, 32'h1234);
        tick(); d_wready = 0; #1;
        chk("st_wvalid_off", d_wvalid, 0); chk("st_resp", p_resp_valid, 1); chk("st_rdata", p_rdata, 0);
        tick();
        // flush in the same cycle as p_valid: refused
        p_valid = 1; flush = 1; #1;
        chk("flush_same_p_ready", p_ready, 0);
        tick(); p_valid = 0; flush = 0; #1;
        chk("flush_same_rvalid", d_rvalid | d_wvalid, 0);
        // contention from reset: pipeline, cacop, pipeline
        rst = 1; #1; rst = 0;
        p_valid = 1; p_op = 1; c_valid = 1; c_type = 1; c_addr = 32'h40; #1;
        chk("ct_g0_p", p_ready, 1); chk("ct_g0_c", c_ready, 0);
        tick(); d_wready = 1; #1;
        chk("ct_wvalid", d_wvalid, 1);
        tick(); d_wready = 0; #1;
        chk("ct_g1_p", p_ready, 0); chk("ct_g1_c", c_ready, 1);
        tick(); d_cacop_ready = 1; d_cacop_done = 1; #1;
        chk("ct_cacop_en", d_cacop_en, 1);
        tick(); d_cacop_ready = 0; d_cacop_done = 0; #1;
        chk("ct_g2_p", p_ready, 1); chk("ct_g2_c", c_ready, 0); chk("ct_c_done", c_done, 1);
        tick(); p_valid = 0; c_valid = 0; d_wready = 1;
        tick(); d_wready = 0;
        tick();
        // flush while a load is outstanding
        p_valid = 1; p_op = 0; p_addr = 32'h300; #1;
        chk("fl_p_ready", p_ready, 1);
        tick(); p_valid = 0; #1;
        chk("fl_rvalid_c1", d_rvalid, 1);
        tick(); flush = 1;
        tick(); flush = 0; #1;
        chk("fl_rvalid_c3", d_rvalid, 1);
        tick(); chk("fl_rvalid_c4", d_rvalid, 1);
        tick(); chk("fl_rvalid_c5", d_rvalid, 1); chk("fl_resp_c5", p_resp_valid, 0);
        tick(); d_rready = 1; d_rdata = 32'h5555_AAAA; #1;
        chk("fl_rvalid_c6", d_rvalid, 1);
        tick(); d_rready = 0; p_valid = 1; p_addr = 32'h400; #1;
        chk("fl_rvalid_c7", d_rvalid, 0); chk("fl_resp_c7", p_resp_valid, 0); chk("fl_new_ready", p_ready, 1);
        tick(); p_valid = 0; d_rready = 1; d_rdata = 32'hCAFE_0001; #1;
        chk("fl_new_addr", d_addr, 32'h400);
        tick(); d_rready = 0; #1;
        chk("fl_new_resp", p_resp_valid, 1); chk("fl_new_rdata", p_rdata, 32'hCAFE_0001);
        tick();
        // cacop with pipeline held waiting (pipeline was granted last)
        c_valid = 1; c_type = 2; c_addr = 32'h80; p_valid = 1; p_op = 0; p_addr = 32'h500; #1;
        chk("cc_c_ready", c_ready, 1); chk("cc_p_ready_c0", p_ready, 0);
        tick(); c_valid = 0; #1;
        chk("cc_en_c1", d_cacop_en, 1); chk("cc_type", d_cacop_type, 2); chk("cc_addr", d_cacop_addr, 32'h80);
        tick(); chk("cc_en_c2", d_cacop_en, 1);
        tick(); d_cacop_ready = 1; #1;
        chk("cc_en_c3", d_cacop_en, 1);
        tick(); d_cacop_ready = 0; #1;
        chk("cc_en_c4", d_cacop_en, 0); chk("cc_p_ready_c4", p_ready, 0);
        for (int i = 5; i < 8; i++) begin
            tick(); chk("cc_wait_p_ready", p_ready, 0); chk("cc_wait_c_done", c_done, 0);
        end
        tick(); d_cacop_done = 1; #1;
        chk("cc_done_c8", c_done, 0);
        tick(); d_cacop_done = 0; #1;
        chk("cc_done_c9", c_done, 1); chk("cc_p_ready_c9", p_ready, 1);
        tick(); p_valid = 0; d_rready = 1; d_rdata = 32'h0000_00AB; #1;
        chk("cc_c_done_c10", c_done, 0); chk("cc_p_addr", d_addr, 32'h500);
        tick(); d_rready = 0; #1;
        chk("cc_p_resp", p_resp_valid, 1); chk("cc_p_rdata", p_rdata, 32'hAB);
        tick();
        // async reset while a load waits in MEM_WAIT
        p_valid = 1; p_op = 0; p_addr = 32'h600; #1;
        tick(); #1;
        chk("ar_rvalid_before", d_rvalid, 1);
        rst = 1; #1;
        chk("ar_outs", {p_ready, p_resp_valid, c_ready, c_done, d_rvalid, d_wvalid, d_cacop_en, d_addr}, 0);
        rst = 0; p_addr = 32'h700; #1;
        chk("ar_p_ready", p_ready, 1);
        tick(); p_valid = 0; d_rready = 1; d_rdata = 32'h7777_0000; #1;
        chk("ar_rvalid", d_rvalid, 1); chk("ar_addr", d_addr, 32'h700);
        tick(); d_rready = 0; #1;
        chk("ar_resp", p_resp_valid, 1); chk("ar_rdata", p_rdata, 32'h7777_0000);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
